// File: rtl/byte_serial_pkg.sv
// Shared types and constants for the byte-serial multi-precision adder.
package byte_serial_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte counter width; sized to hold NBYTES itself.
  function automatic int unsigned cnt_w(input int unsigned nbytes);
    return $clog2(nbytes + 1);
  endfunction

endpackage

// File: rtl/byte_serial_adder_slice.sv
// 8-bit ripple-carry slice: the only arithmetic in the byte-serial adder.
module add8_slice
  import byte_serial_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + (BYTE_W + 1)'(cin);
  end

endmodule

// File: rtl/byte_serial_adder.sv
// Multi-precision adder: NBYTES-byte operands summed one byte per clock through
// a single 8-bit slice, with valid/ready handshakes on both sides.
module byte_serial_adder
  import byte_serial_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     overflow
);

  localparam int unsigned W  = BYTE_W * NBYTES;
  localparam int unsigned CW = cnt_w(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_t              state;
  logic [W-1:0]        a_sh;
  logic [W-1:0]        b_sh;
  logic [W-1:0]        res;
  logic [W-1:0]        res_next;
  logic                carry;
  logic [CW-1:0]       cnt;
  logic                sa;
  logic                sb;
  logic [BYTE_W-1:0]   s8;
  logic                c8;

  add8_slice u_slice (
    .a    (a_sh[BYTE_W-1:0]),
    .b    (b_sh[BYTE_W-1:0]),
    .cin  (carry),
    .sum  (s8),
    .cout (c8)
  );

  // New byte enters at the MSB end; written as a wide shift so NBYTES=1 needs no special case.
  always_comb begin
    res_next = W'({s8, res} >> BYTE_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            sa       <= a[W-1];
            sb       <= b[W-1];
            in_ready <= 1'b0;
            state    <= ADD;
          end
        end
        ADD: begin
          a_sh  <= a_sh >> BYTE_W;
          b_sh  <= b_sh >> BYTE_W;
          carry <= c8;
          res   <= res_next;
          cnt   <= cnt + 1'b1;
          // Published separately from res so outputs hold through the next operation.
          if (cnt == LAST) begin
            sum       <= res_next;
            cout      <= c8;
            overflow  <= (sa == sb) && (s8[BYTE_W-1] != sa);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
